// File: rtl/ripple_add_sequencer.sv
// Sequential WIDTH-bit adder: one shared 4-bit ripple slice, one nibble per clock.
// Optional RIPPLE_SEQ_SUB_EN adds a 'sub' port for a - b via a + ~b + 1.

module ripple_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module ripple_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  assign co   = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    ripple_full_adder u_fa (
      .x (x[i]),
      .y (y[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end
endmodule

module ripple_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RIPPLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("ripple_add_sequencer: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;

`ifdef RIPPLE_SEQ_SUB_EN
  // Subtraction is folded into the captured operands so the datapath only ever adds.
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign nib_a = op_a[4*idx +: 4];
  assign nib_b = op_b[4*idx +: 4];

  ripple_slice4 u_slice (
    .x (nib_a),
    .y (nib_b),
    .ci(carry),
    .s (nib_s),
    .co(nib_co)
  );

  // The final nibble must reach sum on the same edge it is computed.
  always_comb begin
    acc_next = acc;
    acc_next[4*idx +: 4] = nib_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b_in;
            carry <= cin_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= nib_co;
          idx   <= idx + 1'b1;
          if (idx == IW'(NIB - 1)) begin
            sum   <= acc_next;
            cout  <= nib_co;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Bench for ripple_add_sequencer (WIDTH=16): vector table, random ops against an
// arithmetic model, and hand-written sequences for overlap, reset and back-to-back.

module tb_ripple_add_sequencer;
  localparam int W = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int compared;
  int mismatched;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] expSum;
    logic         expCout;
  } vec_t;

  vec_t vecs[$];

  ripple_add_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef RIPPLE_SEQ_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, sum} is simply the (W+1)-bit result of the arithmetic.
  function automatic logic [W:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
    int unsigned total;
    if (s) total = int'(x) + (32'hFFFF - int'(y)) + 1;
    else   total = int'(x) + int'(y) + int'(c);
    return total[W:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one operation, scrambling the inputs while busy, and checks timing and result.
  task automatic applyStimulus(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                               input logic tcin, input logic tsub);
    logic [W:0] expected;
    int n;
    int busyCycles;
    expected = refModel(ta, tb2, tcin, tsub);
    @(negedge clk);
    a = ta; b = tb2; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busyCycles = 0;
    while (!done && n < 20) begin
      if (busy) busyCycles++;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput({name, " latency"}, n, NIB);
    checkOutput({name, " busy cycles"}, busyCycles, NIB);
    checkOutput({name, " sum"}, 32'(sum), 32'(expected[W-1:0]));
    checkOutput({name, " cout"}, 32'(cout), 32'(expected[W]));
    @(negedge clk);
    checkOutput({name, " done drop"}, 32'(done), 0);
    sub = 1'b0;
  endtask

  initial begin
    int n;
    int doneCount;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic rs;
    compared = 0;
    mismatched = 0;

    vecs.push_back('{va:16'h1234, vb:16'h4321, vcin:1'b0, vsub:1'b0, expSum:16'h5555, expCout:1'b0});
    vecs.push_back('{va:16'hFFFF, vb:16'h0001, vcin:1'b0, vsub:1'b0, expSum:16'h0000, expCout:1'b1});
    vecs.push_back('{va:16'hFFFF, vb:16'h0000, vcin:1'b1, vsub:1'b0, expSum:16'h0000, expCout:1'b1});
    vecs.push_back('{va:16'h0000, vb:16'h0000, vcin:1'b0, vsub:1'b0, expSum:16'h0000, expCout:1'b0});
    vecs.push_back('{va:16'hA5A5, vb:16'h5A5A, vcin:1'b1, vsub:1'b0, expSum:16'h0000, expCout:1'b1});
    vecs.push_back('{va:16'h0F0F, vb:16'h00F1, vcin:1'b0, vsub:1'b0, expSum:16'h1000, expCout:1'b0});
    vecs.push_back('{va:16'h8000, vb:16'h8000, vcin:1'b0, vsub:1'b0, expSum:16'h0000, expCout:1'b1});
`ifdef RIPPLE_SEQ_SUB_EN
    vecs.push_back('{va:16'h0005, vb:16'h0007, vcin:1'b0, vsub:1'b1, expSum:16'hFFFE, expCout:1'b0});
    vecs.push_back('{va:16'h0007, vb:16'h0005, vcin:1'b1, vsub:1'b1, expSum:16'h0002, expCout:1'b1});
`endif

    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst = 1'b1;
    #2;
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset sum", 32'(sum), 0);
    checkOutput("reset cout", 32'(cout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors: expected values are literal, independent of the model.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub);
      checkOutput($sformatf("vec%0d table sum", i), 32'(sum), 32'(vecs[i].expSum));
      checkOutput($sformatf("vec%0d table cout", i), 32'(cout), 32'(vecs[i].expCout));
    end

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef RIPPLE_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      applyStimulus($sformatf("rand%0d", i), ra, rb, rc, rs);
    end

    // A second start two cycles into RUN must be ignored.
    @(negedge clk);
    a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hBEEF; b = 16'hCAFE;
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("overlap done count", doneCount, 1);
    checkOutput("overlap sum", 32'(sum), 32'h0100);
    checkOutput("overlap cout", 32'(cout), 0);

    // Leave a nonzero sum and cout=1 behind so the reset clear is observable.
    applyStimulus("pre-reset", 16'hFFFF, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrun reset busy", 32'(busy), 0);
    checkOutput("midrun reset done", 32'(done), 0);
    checkOutput("midrun reset sum", 32'(sum), 0);
    checkOutput("midrun reset cout", 32'(cout), 0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("discarded op done count", doneCount, 0);
    applyStimulus("post-reset", 16'h0001, 16'h0001, 1'b0, 1'b0);
    checkOutput("post-reset sum", 32'(sum), 32'h0002);

    // Back-to-back: new start accepted in the done cycle; sum holds meanwhile.
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("b2b first done", 32'(done), 1);
    checkOutput("b2b first sum", 32'(sum), 32'h0000);
    checkOutput("b2b first cout", 32'(cout), 1);
    a = 16'h0003; b = 16'h0004; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      checkOutput("b2b hold sum", 32'(sum), 32'h0000);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("b2b second latency", n, NIB);
    checkOutput("b2b second sum", 32'(sum), 32'h0007);
    checkOutput("b2b second cout", 32'(cout), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ripple_add_sequencer.md
Name: ripple_add_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit add using one shared 4-bit ripple-carry adder slice, one nibble per clock.
- The slice is built from 4 chained full adders and is instantiated inside this block.
- The carry between nibbles is held in a register.
- Sits between a requester (start/done handshake) and wide-operand datapaths where a full-width adder costs too much area.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8; elaboration fails otherwise.
- NIB, WIDTH/4, derived (localparam): number of nibble passes per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in to nibble 0; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  carry out of the MSB nibble; holds with sum.

Behaviour:
- Reset (async, any time): all of the following clear to 0 immediately:
  - state → IDLE, busy=0, done=0, sum=0, cout=0;
  - operand, carry, accumulator and nibble-index registers.
  - Any in-flight operation is discarded; no done is issued for it.
- FSM has two states, IDLE and RUN.
- IDLE:
  - busy=0.
  - start=1 at a rising edge (the accepting edge E0) → register a, b and cin; idx=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - busy=1.
  - Each edge feeds nibble idx of the captured A/B plus the carry register into the slice.
  - The 4-bit slice result is written into accumulator bits [4*idx+3 : 4*idx]; the slice carry-out is written to the carry register; idx increments.
  - On the edge where idx=NIB-1: sum ← full accumulator (including the final nibble), cout ← final slice carry, done ← 1, state → IDLE.
- Latency:
  - done is high in the cycle following edge E(NIB), i.e. NIB edges after E0. With WIDTH=16 that is 4 edges.
  - busy is high for exactly NIB cycles.
- done:
  - Registered, high for exactly one cycle.
  - Cleared on the next edge unless that same edge completes another operation; this cannot happen when NIB ≥ 2.
- Operand stability:
  - a, b and cin are don't-care after E0; changing them during RUN does not affect the result.
- start while busy=1: ignored, not queued; no error flag.
- Back-to-back operation:
  - start=1 during the done cycle is accepted, because the state is already IDLE.
  - The new operation runs while sum/cout keep the previous result until its own completion.
- sum and cout change only on a completion edge or on reset; partial results are never visible on sum.
- Arithmetic is unsigned modulo 2^WIDTH. cout = bit WIDTH of a + b + cin.

Optional Feature:
- Macro: RIPPLE_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured at E0 with the operands.
  - sub=1 → computes a − b as a + ~b + 1. The captured b is inverted and carry-in forced to 1; the cin port is ignored.
  - cout=1 means no borrow (a ≥ b).
  - sub=0 → plain add as above.
- Undefined: no sub port; the block always adds.

Test Plan (WIDTH=16):
- a=0x1234, b=0x4321, cin=0, start pulse → busy high 4 cycles; done one cycle, 4 edges after E0; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1; checks the carry ripples across all 4 nibble passes. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Start 0x00F0+0x0010; pulse start again with 0x1111+0x1111 two cycles later and change a/b mid-RUN → only one done; sum=0x0100, cout=0; the second start is ignored.
- Start an add, then assert rst in the middle of the second nibble pass → busy/done/sum/cout=0 immediately. After release, a new 0x0001+0x0001 gives sum=0x0002 and exactly one done.
- Back-to-back: 0x8000+0x8000, then start asserted in its done cycle with 0x0003+0x0004 → first done: sum=0x0000, cout=1. sum stays 0x0000 for 4 cycles, then second done: sum=0x0007, cout=0.
- RIPPLE_SEQ_SUB_EN defined, sub=1: 0x0005−0x0007 → sum=0xFFFE, cout=0. 0x0007−0x0005 → sum=0x0002, cout=1.
